axil_slave_mem: RTL and testbench

AXIL_SLAVE_MEM -- requirements
Module: axil_slave_mem

---
 rtl/axil_slave_pkg.sv | 19 +
 rtl/axil_wstrb_ram.sv | 42 ++++
 rtl/axil_slave_mem.sv | 194 +++++++++++++++++++
 tb/tb_axil_slave_mem.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_slave_pkg.sv
// Shared response codes and channel FSM state types for the AXI4-Lite word memory.
package axil_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_WAIT_W,
    WR_WAIT_AW,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_wstrb_ram.sv
// Byte-enable word memory: one write port, one registered read port.
// A read and a write to the same word on one edge return the old contents.
module axil_wstrb_ram #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 16,
  parameter int IDX_W     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_re,
  input  logic                i_rclr,
  input  logic [IDX_W-1:0]    i_raddr,
  output logic [DATA_W-1:0]   o_rdata
);

  logic [DATA_W-1:0] r_mem [NUM_WORDS];
  logic [DATA_W-1:0] r_rdata;

  // byte-masked write; reset clears every word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // registered read; i_rclr loads zero for out-of-range accesses
  always_ff @(posedge clk) begin
    if (rst || i_rclr) r_rdata <= '0;
    else if (i_re)     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave exposing C_NUM_WORDS 32-bit words with byte strobes and a
// completed-write counter. Write and read channels run independently.
//
// state      | meaning
// WR_IDLE    | AWREADY=1, WREADY=1, waiting for either half of a write
// WR_WAIT_W  | address latched, only WREADY=1
// WR_WAIT_AW | data/strobe latched, only AWREADY=1
// WR_RESP    | memory updated, BVALID held until BREADY
// RD_IDLE    | ARREADY=1
// RD_DATA    | RVALID=1 with RDATA/RRESP held until RREADY
module axil_slave_mem
  import axil_slave_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int C_NUM_WORDS        = 16
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [15:0]                     WR_COUNT
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int SW     = C_S_AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(C_NUM_WORDS);
  localparam int LIMIT  = 4 * C_NUM_WORDS;

  wr_state_t                       r_wr_state;
  rd_state_t                       r_rd_state;
  logic                            r_awready, r_wready, r_bvalid;
  logic                            r_arready, r_rvalid;
  logic [1:0]                      r_bresp, r_rresp;
  logic [15:0]                     r_wr_count;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic [DW-1:0]                   r_wdata;
  logic [SW-1:0]                   r_wstrb;

  logic                            w_aw_hs, w_w_hs, w_ar_hs;
  logic                            w_commit, w_cm_oor, w_ar_oor;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   w_cm_addr;
  logic [DW-1:0]                   w_cm_data;
  logic [SW-1:0]                   w_cm_strb;

  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID  & r_wready;
  assign w_ar_hs = S_AXI_ARVALID & r_arready;

  // pick the address/data halves that complete a write on this edge
  always_comb begin
    w_commit  = 1'b0;
    w_cm_addr = S_AXI_AWADDR;
    w_cm_data = S_AXI_WDATA;
    w_cm_strb = S_AXI_WSTRB;
    case (r_wr_state)
      WR_IDLE:    w_commit = w_aw_hs & w_w_hs;
      WR_WAIT_W: begin
        w_commit  = w_w_hs;
        w_cm_addr = r_awaddr;
      end
      WR_WAIT_AW: begin
        w_commit  = w_aw_hs;
        w_cm_data = r_wdata;
        w_cm_strb = r_wstrb;
      end
      default:    w_commit = 1'b0;
    endcase
  end

  assign w_cm_oor = (32'(w_cm_addr)    >= 32'(LIMIT));
  assign w_ar_oor = (32'(S_AXI_ARADDR) >= 32'(LIMIT));

  // write channel FSM with registered handshake outputs and completion counter
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_count <= '0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          if (w_aw_hs && !w_w_hs) begin
            r_awaddr   <= S_AXI_AWADDR;
            r_awready  <= 1'b0;
            r_wr_state <= WR_WAIT_W;
          end else if (w_w_hs && !w_aw_hs) begin
            r_wdata    <= S_AXI_WDATA;
            r_wstrb    <= S_AXI_WSTRB;
            r_wready   <= 1'b0;
            r_wr_state <= WR_WAIT_AW;
          end
        end
        WR_RESP: begin
          if (S_AXI_BREADY) begin
            r_bvalid   <= 1'b0;
            r_wr_count <= r_wr_count + 16'd1;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: ;
      endcase
      if (w_commit) begin
        r_awready  <= 1'b0;
        r_wready   <= 1'b0;
        r_bvalid   <= 1'b1;
        r_bresp    <= w_cm_oor ? RESP_SLVERR : RESP_OKAY;
        r_wr_state <= WR_RESP;
      end
    end
  end

  // read channel FSM; data itself is registered inside the RAM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rresp    <= w_ar_oor ? RESP_SLVERR : RESP_OKAY;
            r_rd_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  axil_wstrb_ram #(
    .DATA_W    (DW),
    .NUM_WORDS (C_NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_we    (w_commit & ~w_cm_oor),
    .i_waddr (w_cm_addr[IDX_W+1:2]),
    .i_wdata (w_cm_data),
    .i_wstrb (w_cm_strb),
    .i_re    (w_ar_hs & ~w_ar_oor),
    .i_rclr  (w_ar_hs & w_ar_oor),
    .i_raddr (S_AXI_ARADDR[IDX_W+1:2]),
    .o_rdata (S_AXI_RDATA)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign WR_COUNT      = r_wr_count;

endmodule

// File: tb/tb_axil_slave_mem.sv
// Bench for axil_slave_mem: transaction-level memory model checked every cycle,
// directed scenarios with literal expectations, then randomized concurrent traffic.
module tb_axil_slave_mem;

  localparam int NW = 16;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [7:0]  S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [7:0]  S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [15:0] WR_COUNT;

  always #5 ACLK = ~ACLK;

  axil_slave_mem #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (8),
    .C_NUM_WORDS        (NW)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .WR_COUNT      (WR_COUNT)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: word array, pending write halves, outstanding responses
  logic [31:0] mdl_mem [NW];
  logic [15:0] mdl_cnt;
  logic        have_aw, have_w, up;
  logic [7:0]  p_addr;
  logic [31:0] p_data;
  logic [3:0]  p_strb;
  logic [1:0]  bq [$];
  logic [33:0] rq [$];
  bit          rand_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake expected one within 200 cycles at %0t", name, $time);
  endtask

  // per-cycle compare against the model, then advance the model by the handshakes
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        for (int i = 0; i < NW; i++) mdl_mem[i] = '0;
        mdl_cnt = '0;
        have_aw = 1'b0;
        have_w  = 1'b0;
        up      = 1'b0;
        bq.delete();
        rq.delete();
      end else begin
        chk("wr_count", 32'(WR_COUNT), 32'(mdl_cnt));
        chk("bvalid", 32'(S_AXI_BVALID), 32'(bq.size() != 0));
        if (bq.size() != 0) chk("bresp", 32'(S_AXI_BRESP), 32'(bq[0]));
        chk("rvalid", 32'(S_AXI_RVALID), 32'(rq.size() != 0));
        if (rq.size() != 0) begin
          chk("rdata", S_AXI_RDATA, rq[0][31:0]);
          chk("rresp", 32'(S_AXI_RRESP), 32'(rq[0][33:32]));
        end
        chk("awready", 32'(S_AXI_AWREADY), 32'(up && !have_aw && bq.size() == 0));
        chk("wready",  32'(S_AXI_WREADY),  32'(up && !have_w  && bq.size() == 0));
        chk("arready", 32'(S_AXI_ARREADY), 32'(up && rq.size() == 0));

        if (S_AXI_BVALID && S_AXI_BREADY && bq.size() != 0) begin
          void'(bq.pop_front());
          mdl_cnt = mdl_cnt + 16'd1;
        end
        if (S_AXI_RVALID && S_AXI_RREADY && rq.size() != 0) void'(rq.pop_front());
        if (S_AXI_ARVALID && S_AXI_ARREADY) begin
          if (S_AXI_ARADDR >= 8'd64) rq.push_back({2'b10, 32'h0});
          else                       rq.push_back({2'b00, mdl_mem[S_AXI_ARADDR[5:2]]});
        end
        if (S_AXI_AWVALID && S_AXI_AWREADY) begin
          have_aw = 1'b1;
          p_addr  = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && S_AXI_WREADY) begin
          have_w = 1'b1;
          p_data = S_AXI_WDATA;
          p_strb = S_AXI_WSTRB;
        end
        if (have_aw && have_w) begin
          if (p_addr < 8'd64) begin
            for (int b = 0; b < 4; b++)
              if (p_strb[b]) mdl_mem[p_addr[5:2]][8*b +: 8] = p_data[8*b +: 8];
            bq.push_back(2'b00);
          end else begin
            bq.push_back(2'b10);
          end
          have_aw = 1'b0;
          have_w  = 1'b0;
        end
        up = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] a, input int d);
    int n = 0;
    repeat (d) tick();
    S_AXI_AWADDR  = a;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    while (!S_AXI_AWREADY && n < 200) begin n++; @(negedge ACLK); end
    if (n >= 200) timeout("aw_handshake");
    tick();
    S_AXI_AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] dat, input logic [3:0] s, input int d);
    int n = 0;
    repeat (d) tick();
    S_AXI_WDATA  = dat;
    S_AXI_WSTRB  = s;
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    while (!S_AXI_WREADY && n < 200) begin n++; @(negedge ACLK); end
    if (n >= 200) timeout("w_handshake");
    tick();
    S_AXI_WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] a);
    int n = 0;
    S_AXI_ARADDR  = a;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    while (!S_AXI_ARREADY && n < 200) begin n++; @(negedge ACLK); end
    if (n >= 200) timeout("ar_handshake");
    tick();
    S_AXI_ARVALID = 1'b0;
  endtask

  // lat = edges from the completing handshake to the first cycle the response is seen
  task automatic wait_b(output logic [1:0] resp, output int lat);
    int n = 0;
    lat = 1;
    @(negedge ACLK);
    while (!(S_AXI_BVALID && S_AXI_BREADY) && n < 200) begin
      n++;
      if (!S_AXI_BVALID) lat++;
      @(negedge ACLK);
    end
    if (n >= 200) timeout("b_handshake");
    resp = S_AXI_BRESP;
    tick();
  endtask

  task automatic wait_r(output logic [31:0] dat, output logic [1:0] resp, output int lat);
    int n = 0;
    lat = 1;
    @(negedge ACLK);
    while (!(S_AXI_RVALID && S_AXI_RREADY) && n < 200) begin
      n++;
      if (!S_AXI_RVALID) lat++;
      @(negedge ACLK);
    end
    if (n >= 200) timeout("r_handshake");
    dat  = S_AXI_RDATA;
    resp = S_AXI_RRESP;
    tick();
  endtask

  // order 0: AW and W together, 1: AW leads by gap, 2: W leads by gap
  task automatic do_write(input logic [7:0] a, input logic [31:0] dat, input logic [3:0] s,
                          input int order, input int gap, output logic [1:0] resp, output int lat);
    case (order)
      1:       fork send_aw(a, 0);   send_w(dat, s, gap); join
      2:       fork send_aw(a, gap); send_w(dat, s, 0);   join
      default: fork send_aw(a, 0);   send_w(dat, s, 0);   join
    endcase
    wait_b(resp, lat);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] dat, output logic [1:0] resp,
                         output int lat);
    send_ar(a);
    wait_r(dat, resp, lat);
  endtask

  logic [1:0]  resp, rresp;
  logic [31:0] rdat, exp_w;
  int          lat;

  initial begin
    // reset values and first READY after release
    ARESET = 1'b1;
    repeat (3) tick();
    @(negedge ACLK);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
    chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
    chk("rst_wr_count", 32'(WR_COUNT), 32'd0);
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("ready_first_cycle", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
    @(negedge ACLK);
    chk("ready_second_cycle", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);
    tick();

    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;

    // simultaneous AW/W write
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, resp, lat);
    chk("w04_bresp", 32'(resp), 32'd0);
    chk("w04_blat", 32'(lat), 32'd1);
    chk("w04_count", 32'(WR_COUNT), 32'd1);

    // strobed overwrite
    do_write(8'h08, 32'h11223344, 4'hF, 1, 2, resp, lat);
    do_write(8'h08, 32'hAABBCCDD, 4'h5, 0, 0, resp, lat);
    do_read(8'h08, rdat, rresp, lat);
    chk("r08_data", rdat, 32'h11BB33DD);
    chk("r08_rresp", 32'(rresp), 32'd0);
    chk("r08_rlat", 32'(lat), 32'd1);

    // W three cycles ahead of AW
    do_write(8'h0C, 32'h00000005, 4'hF, 2, 3, resp, lat);
    chk("w0c_bresp", 32'(resp), 32'd0);
    do_read(8'h0C, rdat, rresp, lat);
    chk("r0c_data", rdat, 32'h00000005);
    chk("w0c_count", 32'(WR_COUNT), 32'd4);

    // out-of-range write and read; address bits alias word 0
    do_write(8'h40, 32'hFFFFFFFF, 4'hF, 0, 0, resp, lat);
    chk("w40_bresp", 32'(resp), 32'd2);
    do_read(8'h40, rdat, rresp, lat);
    chk("r40_data", rdat, 32'h0);
    chk("r40_rresp", 32'(rresp), 32'd2);
    chk("w40_count", 32'(WR_COUNT), 32'd5);
    for (int i = 0; i < NW; i++) begin
      exp_w = (i == 1) ? 32'hDEADBEEF : (i == 2) ? 32'h11BB33DD : (i == 3) ? 32'h5 : 32'h0;
      do_read(8'(i * 4 + (i % 4)), rdat, rresp, lat);
      chk("word_intact", rdat, exp_w);
    end

    // both responses stalled while new requests are offered
    S_AXI_BREADY = 1'b0;
    S_AXI_RREADY = 1'b0;
    fork
      send_aw(8'h10, 0);
      send_w(32'hCAFE0001, 4'hF, 0);
      send_ar(8'h04);
    join
    S_AXI_AWADDR  = 8'h14;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARADDR  = 8'h08;
    S_AXI_ARVALID = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge ACLK);
      chk("stall_readys", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
      chk("stall_valids", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd3);
      chk("stall_rdata", S_AXI_RDATA, 32'hDEADBEEF);
      chk("stall_resps", 32'({S_AXI_BRESP, S_AXI_RRESP}), 32'd0);
      chk("stall_count", 32'(WR_COUNT), 32'd5);
    end
    tick();
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_ARVALID = 1'b0;
    S_AXI_BREADY  = 1'b1;
    S_AXI_RREADY  = 1'b1;
    fork
      wait_b(resp, lat);
      wait_r(rdat, rresp, lat);
    join
    tick();
    chk("stall_done_count", 32'(WR_COUNT), 32'd6);

    // randomized concurrent traffic with random response back-pressure
    rand_rdy = 1'b1;
    fork
      begin
        while (rand_rdy) begin
          S_AXI_BREADY = 1'($urandom_range(0, 1));
          S_AXI_RREADY = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join_none
    fork
      begin
        logic [1:0] wr_resp;
        int         wr_lat;
        for (int k = 0; k < 60; k++) begin
          logic [7:0] a;
          a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
          do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), wr_resp, wr_lat);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        logic [31:0] rd_dat;
        logic [1:0]  rd_resp;
        int          rd_lat;
        for (int k = 0; k < 60; k++) begin
          logic [7:0] a;
          a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
          do_read(a, rd_dat, rd_resp, rd_lat);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    join
    rand_rdy = 1'b0;
    repeat (2) tick();
    S_AXI_BREADY = 1'b1;
    S_AXI_RREADY = 1'b1;
    repeat (2) tick();

    // write fill of word 0, then reset while waiting for W
    do_write(8'h00, 32'h0BADF00D, 4'hF, 0, 0, resp, lat);
    send_aw(8'h00, 0);
    ARESET = 1'b1;
    repeat (2) tick();
    @(negedge ACLK);
    chk("abort_rdata", S_AXI_RDATA, 32'h0);
    chk("abort_bvalid", 32'(S_AXI_BVALID), 32'd0);
    tick();
    ARESET = 1'b0;
    repeat (3) tick();
    @(negedge ACLK);
    chk("abort_bvalid_after", 32'(S_AXI_BVALID), 32'd0);
    chk("abort_count", 32'(WR_COUNT), 32'd0);
    tick();
    do_read(8'h00, rdat, rresp, lat);
    chk("abort_word0", rdat, 32'h0);
    do_read(8'h04, rdat, rresp, lat);
    chk("abort_word1", rdat, 32'h0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
